// File: rtl/hazard_ctrl_pkg.sv
// Hazard control shared types: forward-select codes, shadow slot record,
// register-number width and the forward priority helper.
package hazard_ctrl_pkg;

  localparam int REG_W = 3;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } slot_t;

  // Youngest producer wins; a load still in EX never forwards
  // because the consumer is stalled instead.
  function automatic logic [1:0] fwd_sel(
    input logic ex_hit,
    input logic ex_memread,
    input logic mem_hit
  );
    if (ex_hit && !ex_memread) return FWD_EXMEM;
    if (mem_hit)               return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_slot_match.sv
// One shadow slot versus one ID source register.
// Ports: slot record, src number, used flag -> hit.
module hazard_slot_match
  import hazard_ctrl_pkg::*;
(
  input  slot_t            slot,
  input  logic [REG_W-1:0] src,
  input  logic             used,
  output logic             hit
);

  assign hit = slot.valid & slot.regwrite & used &
               (slot.rd == src);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use stall, redirect flush, EX forward select.
// Ports: clk/rst, ID sources+dest, ex_redirect -> stall, flush,
// forwardA/B, stall_cnt. Macro HAZARD_FORWARD_EN enables forwarding.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_valid,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic [15:0]      stall_cnt
);

  slot_t ex_q;
  slot_t mem_q;
  slot_t wb_q;
  slot_t ex_d;

  logic ex_rs_hit;
  logic ex_rt_hit;
  logic mem_rs_hit;
  logic mem_rt_hit;
  logic ex_hit;
  logic mem_hit;
  logic bubble;

  hazard_slot_match u_ex_rs (
    .slot (ex_q),
    .src  (id_rs),
    .used (id_rs_used),
    .hit  (ex_rs_hit)
  );

  hazard_slot_match u_ex_rt (
    .slot (ex_q),
    .src  (id_rt),
    .used (id_rt_used),
    .hit  (ex_rt_hit)
  );

  hazard_slot_match u_mem_rs (
    .slot (mem_q),
    .src  (id_rs),
    .used (id_rs_used),
    .hit  (mem_rs_hit)
  );

  hazard_slot_match u_mem_rt (
    .slot (mem_q),
    .src  (id_rt),
    .used (id_rt_used),
    .hit  (mem_rt_hit)
  );

  assign ex_hit  = ex_rs_hit | ex_rt_hit;
  assign mem_hit = mem_rs_hit | mem_rt_hit;

  assign flush = ex_redirect & ~rst;

`ifdef HAZARD_FORWARD_EN
  assign stall = ex_hit & ex_q.memread & id_valid &
                 ~flush & ~rst;
`else
  // Without bypass paths any in-flight producer must drain to WB.
  assign stall = (ex_hit | mem_hit) & id_valid &
                 ~flush & ~rst;
`endif

  assign bubble = stall | flush | ~id_valid;

  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

`ifdef HAZARD_FORWARD_EN
  logic [1:0] fa_d;
  logic [1:0] fb_d;

  assign fa_d = bubble ? FWD_RF :
    fwd_sel(ex_rs_hit, ex_q.memread, mem_rs_hit);
  assign fb_d = bubble ? FWD_RF :
    fwd_sel(ex_rt_hit, ex_q.memread, mem_rt_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      forwardA <= FWD_RF;
      forwardB <= FWD_RF;
    end else begin
      forwardA <= fa_d;
      forwardB <= fb_d;
    end
  end
`else
  assign forwardA = FWD_RF;
  assign forwardB = FWD_RF;
`endif

  // WB slot only mirrors the pipeline; the register file
  // resolves its hazards by writing before reading.
  logic unused;
  assign unused = ^wb_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed cycles push expected
// outputs; a negedge monitor pops and compares. Follows HAZARD_FORWARD_EN.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [2:0] rs;
    logic       rsu;
    logic [2:0] rt;
    logic       rtu;
    logic [2:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  id_rs = '0;
  logic [2:0]  id_rt = '0;
  logic        id_rs_used = 1'b0;
  logic        id_rt_used = 1'b0;
  logic [2:0]  id_rd = '0;
  logic        id_regwrite = 1'b0;
  logic        id_memread = 1'b0;
  logic        id_valid = 1'b0;
  logic        ex_redirect = 1'b0;
  logic        stall;
  logic        flush;
  logic [1:0]  forwardA;
  logic [1:0]  forwardB;
  logic [15:0] stall_cnt;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    errors = 0;

  hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_valid    (id_valid),
    .ex_redirect (ex_redirect),
    .stall       (stall),
    .flush       (flush),
    .forwardA    (forwardA),
    .forwardB    (forwardB),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic instr_t alu(
    input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt
  );
    instr_t i;
    i = '{v:1'b1, rs:rs, rsu:1'b1, rt:rt, rtu:1'b1,
          rd:rd, rw:1'b1, mr:1'b0};
    return i;
  endfunction

  function automatic instr_t ld(
    input logic [2:0] rd, input logic [2:0] rs
  );
    instr_t i;
    i = '{v:1'b1, rs:rs, rsu:1'b1, rt:3'd0, rtu:1'b0,
          rd:rd, rw:1'b1, mr:1'b1};
    return i;
  endfunction

  localparam instr_t NOP = '0;

  // Drive one cycle of inputs, queue the outputs expected in it,
  // then advance past the next rising edge.
  task automatic step(
    input string       nm,
    input logic        r,
    input logic        redir,
    input instr_t      i,
    input logic        es,
    input logic        ef,
    input logic [1:0]  fa,
    input logic [1:0]  fb,
    input logic [15:0] cnt
  );
    exp_t e;
    rst         = r;
    ex_redirect = redir;
    id_valid    = i.v;
    id_rs       = i.rs;
    id_rs_used  = i.rsu;
    id_rt       = i.rt;
    id_rt_used  = i.rtu;
    id_rd       = i.rd;
    id_regwrite = i.rw;
    id_memread  = i.mr;
    e = '{stall:es, flush:ef, fa:fa, fb:fb, cnt:cnt};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      vectors++;
      if (stall !== e.stall || flush !== e.flush ||
          forwardA !== e.fa || forwardB !== e.fb ||
          stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s: got stall=%b flush=%b fA=%b fB=%b cnt=%0d, want stall=%b flush=%b fA=%b fB=%b cnt=%0d",
                 n, stall, flush, forwardA, forwardB, stall_cnt,
                 e.stall, e.flush, e.fa, e.fb, e.cnt);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
`ifdef HAZARD_FORWARD_EN
    step("rst_redir",  1, 1, alu(3, 1, 2),  0, 0, 2'b00, 2'b00, 0);
    step("add_r3",     0, 0, alu(3, 1, 2),  0, 0, 2'b00, 2'b00, 0);
    step("sub_dep",    0, 0, alu(4, 3, 1),  0, 0, 2'b00, 2'b00, 0);
    step("sub_in_ex",  0, 0, NOP,           0, 0, 2'b10, 2'b00, 0);
    step("add_r3b",    0, 0, alu(3, 1, 2),  0, 0, 2'b00, 2'b00, 0);
    step("nop_gap",    0, 0, NOP,           0, 0, 2'b00, 2'b00, 0);
    step("rd_rt",      0, 0, alu(6, 1, 3),  0, 0, 2'b00, 2'b00, 0);
    step("rd_rt_ex",   0, 0, NOP,           0, 0, 2'b00, 2'b01, 0);
    step("ld_r2",      0, 0, ld(2, 1),      0, 0, 2'b00, 2'b00, 0);
    step("lu_stall",   0, 0, alu(5, 2, 2),  1, 0, 2'b00, 2'b00, 0);
    step("lu_release", 0, 0, alu(5, 2, 2),  0, 0, 2'b00, 2'b00, 1);
    step("lu_fwd",     0, 0, NOP,           0, 0, 2'b01, 2'b01, 1);
    step("ld_r7",      0, 0, ld(7, 1),      0, 0, 2'b00, 2'b00, 1);
    step("redir_lu",   0, 1, alu(1, 7, 7),  0, 1, 2'b00, 2'b00, 1);
    step("post_flush", 0, 0, alu(2, 1, 0),  0, 0, 2'b00, 2'b00, 1);
    step("no_fwd_bub", 0, 0, NOP,           0, 0, 2'b00, 2'b00, 1);
    step("pre_rst",    0, 0, alu(4, 1, 2),  0, 0, 2'b00, 2'b00, 1);
    step("ld_live",    0, 0, ld(6, 4),      0, 0, 2'b00, 2'b01, 1);
    step("rst_mid",    1, 0, alu(1, 6, 4),  0, 0, 2'b10, 2'b00, 1);
    step("after_rst",  0, 0, alu(1, 6, 4),  0, 0, 2'b00, 2'b00, 0);
    step("no_stale",   0, 0, NOP,           0, 0, 2'b00, 2'b00, 0);
`else
    step("rst_redir",  1, 1, alu(3, 1, 2),  0, 0, 2'b00, 2'b00, 0);
    step("add_r3",     0, 0, alu(3, 1, 2),  0, 0, 2'b00, 2'b00, 0);
    step("dep_ex",     0, 0, alu(4, 3, 1),  1, 0, 2'b00, 2'b00, 0);
    step("dep_mem",    0, 0, alu(4, 3, 1),  1, 0, 2'b00, 2'b00, 1);
    step("dep_go",     0, 0, alu(4, 3, 1),  0, 0, 2'b00, 2'b00, 2);
    step("nop_gap",    0, 0, NOP,           0, 0, 2'b00, 2'b00, 2);
    step("redir_haz",  0, 1, alu(1, 4, 0),  0, 1, 2'b00, 2'b00, 2);
    step("add_r5",     0, 0, alu(5, 1, 2),  0, 0, 2'b00, 2'b00, 2);
    step("rst_mid",    1, 0, alu(6, 5, 0),  0, 0, 2'b00, 2'b00, 2);
    step("after_rst",  0, 0, alu(6, 5, 0),  0, 0, 2'b00, 2'b00, 0);
    step("ld_r2",      0, 0, ld(2, 1),      0, 0, 2'b00, 2'b00, 0);
    step("lu_ex",      0, 0, alu(5, 2, 2),  1, 0, 2'b00, 2'b00, 0);
    step("lu_mem",     0, 0, alu(5, 2, 2),  1, 0, 2'b00, 2'b00, 1);
    step("lu_go",      0, 0, alu(5, 2, 2),  0, 0, 2'b00, 2'b00, 2);
    step("idle",       0, 0, NOP,           0, 0, 2'b00, 2'b00, 2);
`endif
    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
